div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit_pkg.sv | 17 +
 rtl/div_unit_if.sv | 40 ++++
 rtl/div_unit.sv | 139 +++++++++++++
 tb/tb_div_unit.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
// div_unit_pkg -- shared definitions for the iterative divider.
//   div_state_t      : FSM state encodings (DivFree, DivByZero, DivOn, DivEnd)
//   DIV_RESULT_READY : level driven on ready_o when result_o is valid
//   DIV_RESULT_NOT_READY : level driven on ready_o otherwise
package div_unit_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,  // idle, waiting for a request
    DivByZero = 2'b01,  // divisor was zero, produce the flagged zero result
    DivOn     = 2'b10,  // restoring iterations in progress
    DivEnd    = 2'b11   // result held until the requester drops start_i
  } div_state_t;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;

endpackage

// File: rtl/div_unit_if.sv
// div_unit_if -- request/result bundle between the execute stage and div_unit.
//   signed_div_i : 1 = signed division, 0 = unsigned
//   opdata1_i    : dividend
//   opdata2_i    : divisor
//   start_i      : level request
//   annul_i      : abort whatever is in flight
//   result_o     : {remainder, quotient}
//   ready_o      : result_o / dbz_o are valid
//   dbz_o        : divide-by-zero flag
//   busy_o       : divider is not idle
//
// Handshake: the requester raises start_i with operands valid; the operands
// are captured on the single accepting edge and ignored afterwards. start_i
// stays high until the requester has consumed result_o while ready_o=1; the
// divider holds its result until it sees start_i low, then returns to idle
// and clears ready_o/result_o on that edge. A new request is only taken once
// start_i has been observed low after the previous operation ended.
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic                 signed_div_i;
  logic [WIDTH-1:0]     opdata1_i;
  logic [WIDTH-1:0]     opdata2_i;
  logic                 start_i;
  logic                 annul_i;
  logic [2*WIDTH-1:0]   result_o;
  logic                 ready_o;
  logic                 dbz_o;
  logic                 busy_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o, dbz_o, busy_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o, dbz_o, busy_o
  );
endinterface

// File: rtl/div_unit.sv
// div_unit -- multi-cycle restoring radix-2 divider, signed or unsigned.
//   clk     : clock, rising edge
//   rst     : asynchronous active-low reset
//   bus     : div_unit_if slave modport (request in, {rem,quo}/ready/dbz/busy out)
//   state_o : current FSM state, for observation
// One quotient bit is produced per cycle in DivOn; the result becomes valid
// WIDTH+1 edges after the accepting edge (2 edges for a zero divisor).
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic       clk,
  input  logic       rst,
  div_unit_if.slave  bus,
  output div_state_t state_o
);

  localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH);

  div_state_t           state_q;
  logic [CNT_W-1:0]     count_q;
  logic [WIDTH-1:0]     divisor_q;   // divisor magnitude
  logic [WIDTH-1:0]     rem_q;       // partial remainder
  logic [WIDTH-1:0]     quo_q;       // dividend bits shift out, quotient bits shift in
  logic                 neg_quo_q;   // operand signs differ
  logic                 neg_rem_q;   // dividend was negative
  logic                 wait_low_q;  // start_i must be seen low before next accept
  logic [2*WIDTH-1:0]   result_q;
  logic                 ready_q;
  logic                 dbz_q;

  // Operand magnitudes at the accepting edge.
  logic                 neg1, neg2;
  logic [WIDTH-1:0]     mag1, mag2;
  assign neg1 = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
  assign neg2 = bus.signed_div_i & bus.opdata2_i[WIDTH-1];
  assign mag1 = neg1 ? (~bus.opdata1_i + ONE_W) : bus.opdata1_i;
  assign mag2 = neg2 ? (~bus.opdata2_i + ONE_W) : bus.opdata2_i;

  // One restoring step: shift the next dividend bit into the remainder and
  // trial-subtract the divisor. The top bit of trial is the borrow out; when
  // it is clear the subtraction is kept and the quotient bit is 1.
  logic [WIDTH:0]       shifted;
  logic [WIDTH+1:0]     trial;
  logic                 trial_ok;
  logic [WIDTH-1:0]     rem_next;
  logic [WIDTH-1:0]     quo_next;
  assign shifted  = {rem_q, quo_q[WIDTH-1]};
  assign trial    = {1'b0, shifted} - {2'b00, divisor_q};
  assign trial_ok = ~trial[WIDTH+1];
  assign rem_next = trial_ok ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign quo_next = {quo_q[WIDTH-2:0], trial_ok};

  // Sign fixup applied once all iterations are done.
  logic [WIDTH-1:0]     quo_fix, rem_fix;
  assign quo_fix = neg_quo_q ? (~quo_q + ONE_W) : quo_q;
  assign rem_fix = neg_rem_q ? (~rem_q + ONE_W) : rem_q;

  // Any busy state returns to idle on annul; DivEnd also returns when the
  // requester lets go of start_i.
  logic go_idle;
  assign go_idle = ((state_q != DivFree) && bus.annul_i) ||
                   ((state_q == DivEnd) && !bus.start_i);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= DivFree;
      count_q    <= '0;
      divisor_q  <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      wait_low_q <= 1'b0;
      result_q   <= '0;
      ready_q    <= DIV_RESULT_NOT_READY;
      dbz_q      <= 1'b0;
    end else if (go_idle) begin
      state_q    <= DivFree;
      count_q    <= '0;
      divisor_q  <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      wait_low_q <= bus.start_i;
      result_q   <= '0;
      ready_q    <= DIV_RESULT_NOT_READY;
      dbz_q      <= 1'b0;
    end else begin
      if (!bus.start_i) begin
        wait_low_q <= 1'b0;
      end
      case (state_q)
        DivFree: begin
          if (bus.start_i && !bus.annul_i && !wait_low_q) begin
            divisor_q <= mag2;
            rem_q     <= '0;
            quo_q     <= mag1;
            neg_quo_q <= neg1 ^ neg2;
            neg_rem_q <= neg1;
            count_q   <= '0;
            state_q   <= (bus.opdata2_i == '0) ? DivByZero : DivOn;
          end
        end
        DivByZero: begin
          result_q <= '0;
          dbz_q    <= 1'b1;
          state_q  <= DivEnd;
        end
        DivOn: begin
          if (count_q == LAST_CNT) begin
            result_q <= {rem_fix, quo_fix};
            ready_q  <= DIV_RESULT_READY;
            state_q  <= DivEnd;
          end else begin
            rem_q   <= rem_next;
            quo_q   <= quo_next;
            count_q <= count_q + 1'b1;
          end
        end
        DivEnd: begin
          ready_q <= DIV_RESULT_READY;
        end
        default: state_q <= DivFree;
      endcase
    end
  end

  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;
  assign bus.dbz_o    = dbz_q;
  assign bus.busy_o   = (state_q != DivFree);
  assign state_o      = state_q;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit -- directed bench for div_unit at WIDTH=32 and WIDTH=8.
module tb_div_unit;
  import div_unit_pkg::*;

  logic clk = 1'b0;
  logic rst32 = 1'b0;
  logic rst8  = 1'b0;
  always #5 clk = ~clk;

  div_unit_if #(.WIDTH(32)) if32 ();
  div_unit_if #(.WIDTH(8))  if8 ();
  div_state_t st32, st8;

  div_unit #(.WIDTH(32)) u_div32 (.clk(clk), .rst(rst32), .bus(if32.slave), .state_o(st32));
  div_unit #(.WIDTH(8))  u_div8  (.clk(clk), .rst(rst8),  .bus(if8.slave),  .state_o(st8));

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full 32-bit operation; caller is #1 after an edge with the divider idle.
  task automatic op32(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] eq, input logic [31:0] er, input int lat, input logic edbz);
    int n;
    logic [63:0] held;
    if32.signed_div_i = sgn; if32.opdata1_i = a; if32.opdata2_i = b; if32.start_i = 1'b1;
    @(posedge clk); #1;
    check({tag, " busy after accept"}, 128'(if32.busy_o), 128'(1));
    n = 0;
    while (!if32.ready_o && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check({tag, " latency"}, 128'(n), 128'(lat));
    check({tag, " result"}, 128'(if32.result_o), 128'({er, eq}));
    check({tag, " dbz"}, 128'(if32.dbz_o), 128'(edbz));
    held = if32.result_o;
    repeat (2) begin
      if32.opdata1_i = $urandom(); if32.opdata2_i = $urandom(); if32.signed_div_i = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    check({tag, " result held"}, 128'(if32.result_o), 128'(held));
    check({tag, " ready held"}, 128'(if32.ready_o), 128'(1));
    if32.start_i = 1'b0;
    @(posedge clk); #1;
    check({tag, " idle ready"}, 128'(if32.ready_o), 128'(0));
    check({tag, " idle result"}, 128'(if32.result_o), 128'(0));
    check({tag, " idle dbz"}, 128'(if32.dbz_o), 128'(0));
    check({tag, " idle state"}, 128'(st32), 128'(DivFree));
  endtask

  task automatic op8(input string tag, input logic sgn, input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] eq, input logic [7:0] er, input int lat);
    int n;
    if8.signed_div_i = sgn; if8.opdata1_i = a; if8.opdata2_i = b; if8.start_i = 1'b1;
    @(posedge clk); #1;
    n = 0;
    while (!if8.ready_o && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check({tag, " latency"}, 128'(n), 128'(lat));
    check({tag, " result"}, 128'(if8.result_o), 128'({er, eq}));
    check({tag, " dbz"}, 128'(if8.dbz_o), 128'(0));
    if8.start_i = 1'b0;
    @(posedge clk); #1;
    check({tag, " idle ready"}, 128'(if8.ready_o), 128'(0));
    check({tag, " idle busy"}, 128'(if8.busy_o), 128'(0));
  endtask

  initial begin
    if32.signed_div_i = 1'b0; if32.opdata1_i = '0; if32.opdata2_i = '0;
    if32.start_i = 1'b0; if32.annul_i = 1'b0;
    if8.signed_div_i = 1'b0; if8.opdata1_i = '0; if8.opdata2_i = '0;
    if8.start_i = 1'b0; if8.annul_i = 1'b0;

    // Reset state
    #2;
    check("rst32 result", 128'(if32.result_o), 128'(0));
    check("rst32 ready", 128'(if32.ready_o), 128'(0));
    check("rst32 dbz", 128'(if32.dbz_o), 128'(0));
    check("rst32 busy", 128'(if32.busy_o), 128'(0));
    check("rst32 state", 128'(st32), 128'(DivFree));
    check("rst8 busy", 128'(if8.busy_o), 128'(0));
    repeat (2) @(posedge clk);
    #1; rst32 = 1'b1; rst8 = 1'b1;
    @(posedge clk); #1;

    // 32-bit directed divisions
    op32("u100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33, 1'b0);
    op32("s-100/7", 1'b1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 33, 1'b0);
    op32("s100/-7", 1'b1, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2, 33, 1'b0);
    op32("smin/-1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 33, 1'b0);
    op32("umax/16", 1'b0, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF, 32'hF, 33, 1'b0);
    op32("u-100/7", 1'b0, 32'hFFFFFF9C, 32'd7, 32'd613566742, 32'd2, 33, 1'b0);
    op32("dbz", 1'b0, 32'd55, 32'd0, 32'd0, 32'd0, 2, 1'b1);

    // Annul 10 cycles into the iterations
    if32.signed_div_i = 1'b0; if32.opdata1_i = 32'd100; if32.opdata2_i = 32'd7; if32.start_i = 1'b1;
    @(posedge clk); #1;
    check("annul accepted", 128'(st32), 128'(DivOn));
    repeat (10) @(posedge clk);
    #1; if32.annul_i = 1'b1;
    @(posedge clk); #1;
    if32.annul_i = 1'b0;
    check("annul state", 128'(st32), 128'(DivFree));
    check("annul ready", 128'(if32.ready_o), 128'(0));
    check("annul result", 128'(if32.result_o), 128'(0));
    repeat (3) @(posedge clk);
    #1;
    check("annul no restart busy", 128'(if32.busy_o), 128'(0));
    check("annul no restart ready", 128'(if32.ready_o), 128'(0));
    if32.start_i = 1'b0;
    @(posedge clk); #1;
    op32("after annul", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33, 1'b0);

    // start with annul in idle is refused
    if32.start_i = 1'b1; if32.annul_i = 1'b1;
    @(posedge clk); #1;
    check("start+annul busy", 128'(if32.busy_o), 128'(0));
    if32.start_i = 1'b0; if32.annul_i = 1'b0;
    @(posedge clk); #1;

    // 8-bit divisions
    op8("w8 FF/10", 1'b0, 8'hFF, 8'h10, 8'h0F, 8'h0F, 9);
    op8("w8 smin/-1", 1'b1, 8'h80, 8'hFF, 8'h80, 8'h00, 9);

    // Asynchronous reset in the middle of an operation
    if8.signed_div_i = 1'b0; if8.opdata1_i = 8'hFF; if8.opdata2_i = 8'h10; if8.start_i = 1'b1;
    @(posedge clk); #1;
    repeat (4) @(posedge clk);
    #1; rst8 = 1'b0;
    #1;
    check("w8 midrst busy", 128'(if8.busy_o), 128'(0));
    check("w8 midrst ready", 128'(if8.ready_o), 128'(0));
    check("w8 midrst result", 128'(if8.result_o), 128'(0));
    check("w8 midrst dbz", 128'(if8.dbz_o), 128'(0));
    check("w8 midrst state", 128'(st8), 128'(DivFree));
    if8.start_i = 1'b0;
    @(posedge clk); #1;
    rst8 = 1'b1;
    op8("w8 200/9", 1'b0, 8'd200, 8'd9, 8'd22, 8'd2, 9);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
